// File: rtl/photocell_event_gen.sv
// Photocell front end for the bank queue counter.
// Each beam input is synchronised, debounced and rising-edge detected.
// Simultaneous entry/exit events are serialised: up first, then down.
// The resulting up/down pulses are single-cycle and mutually exclusive.
module photocell_event_gen #(
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sens_in,
  input  logic sens_out,
  output logic up,
  output logic down,
  output logic in_level,
  output logic out_level,
  output logic pending,
  output logic collision
);

  // A counter at this value means the current sample is the last differing one needed.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] CNT_ONE = DB_W'(1);

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_PEND_UP   = 2'd1,
    ARB_PEND_DOWN = 2'd2
  } arb_state_t;

  // Channel 0 is the entry beam and channel 1 is the exit beam.
  logic [1:0]      raw;
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      level;
  logic [1:0]      level_prev;
  logic [1:0]      ev;
  logic [DB_W-1:0] cnt [2];

  arb_state_t state;
  arb_state_t state_next;
  logic       up_next;
  logic       down_next;
  logic       coll_next;

  assign raw = {sens_out, sens_in};

  // Two-flop synchroniser for each asynchronous beam input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce: the level flips only after DB_CYCLES consecutive samples that differ from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= 2'b00;
      level_prev <= 2'b00;
      cnt[0]     <= '0;
      cnt[1]     <= '0;
    end else begin
      level_prev <= level;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Only a rising debounced level (beam becoming blocked) is an event.
  assign ev = level & ~level_prev;

  // Arbiter state and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      up        <= 1'b0;
      down      <= 1'b0;
      collision <= 1'b0;
      pending   <= 1'b0;
    end else begin
      state     <= state_next;
      up        <= up_next;
      down      <= down_next;
      collision <= coll_next;
      pending   <= (state_next != ARB_IDLE);
    end
  end

  // Arbiter decisions: a waiting event goes first, a collision issues up and holds down back.
  always_comb begin
    state_next = state;
    up_next    = 1'b0;
    down_next  = 1'b0;
    coll_next  = 1'b0;
    case (state)
      ARB_PEND_UP, ARB_PEND_DOWN: begin
        up_next   = (state == ARB_PEND_UP);
        down_next = (state == ARB_PEND_DOWN);
        if (ev[0]) begin
          state_next = ARB_PEND_UP;
        end else if (ev[1]) begin
          state_next = ARB_PEND_DOWN;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_IDLE: begin
        if (ev[0] && ev[1]) begin
          up_next    = 1'b1;
          coll_next  = 1'b1;
          state_next = ARB_PEND_DOWN;
        end else if (ev[0]) begin
          up_next = 1'b1;
        end else if (ev[1]) begin
          down_next = 1'b1;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign in_level  = level[0];
  assign out_level = level[1];

endmodule

// File: tb/tb_photocell_event_gen.sv
// Directed and randomized bench for photocell_event_gen (DB_CYCLES = 4).
// A reference model tracks delayed samples, run lengths and an event queue.
module tb_photocell_event_gen;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sens_in = 1'b0;
  logic sens_out = 1'b0;
  logic up, down, in_level, out_level, pending, collision;

  int tests = 0;
  int fails = 0;

  // Reference model state (index 0 = entry, 1 = exit).
  bit d1 [2];
  bit d2 [2];
  int run [2];
  bit lvl [2];
  bit lvl_prev [2];
  bit q [$];            // waiting events, 1 = down, 0 = up
  bit e_up, e_down, e_coll;
  int n_up = 0;
  int n_down = 0;

  photocell_event_gen #(.DB_CYCLES(DB), .DB_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sens_in   (sens_in),
    .sens_out  (sens_out),
    .up        (up),
    .down      (down),
    .in_level  (in_level),
    .out_level (out_level),
    .pending   (pending),
    .collision (collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      d1[i] = 1'b0; d2[i] = 1'b0; run[i] = 0; lvl[i] = 1'b0; lvl_prev[i] = 1'b0;
    end
    q.delete();
    e_up = 1'b0; e_down = 1'b0; e_coll = 1'b0;
  endtask

  task automatic model_edge(input bit a, input bit b);
    bit fr [2];
    bit raw [2];
    raw[0] = a;
    raw[1] = b;
    for (int i = 0; i < 2; i++) fr[i] = lvl[i] & ~lvl_prev[i];
    e_up = 1'b0; e_down = 1'b0; e_coll = 1'b0;
    if (q.size() > 0) begin
      if (q.pop_front()) e_down = 1'b1; else e_up = 1'b1;
      if (fr[0]) q.push_back(1'b0);
      if (fr[1]) q.push_back(1'b1);
    end else if (fr[0] && fr[1]) begin
      e_up = 1'b1; e_coll = 1'b1; q.push_back(1'b1);
    end else if (fr[0]) begin
      e_up = 1'b1;
    end else if (fr[1]) begin
      e_down = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      lvl_prev[i] = lvl[i];
      if (d2[i] != lvl[i]) begin
        run[i]++;
        if (run[i] == DB) begin
          lvl[i] = ~lvl[i];
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
      d2[i] = d1[i];
      d1[i] = raw[i];
    end
  endtask

  task automatic check_outputs();
    check("up", up, e_up);
    check("down", down, e_down);
    check("collision", collision, e_coll);
    check("pending", pending, q.size() != 0);
    check("in_level", in_level, lvl[0]);
    check("out_level", out_level, lvl[1]);
    check("exclusive", up & down, 1'b0);
    if (up === 1'b1) n_up++;
    if (down === 1'b1) n_down++;
  endtask

  task automatic step(input bit a, input bit b);
    sens_in = a;
    sens_out = b;
    @(posedge clk);
    if (!rst) model_edge(a, b);
    #1;
    check_outputs();
  endtask

  initial begin
    int cu, cd, rem_b, rem_e, rem_x, total, r, len, ch;
    model_reset();

    // Reset held with toggling sensors.
    for (int k = 0; k < 6; k++) step(k[0], ~k[0]);
    check("rst_up", up, 1'b0);
    check("rst_pending", pending, 1'b0);
    sens_in = 1'b0; sens_out = 1'b0;
    rst = 1'b0;

    // Idle after release: no pulses.
    cu = n_up; cd = n_down;
    for (int k = 0; k < 100; k++) step(1'b0, 1'b0);
    check("idle_ups", n_up - cu, 0);
    check("idle_downs", n_down - cd, 0);

    // Single entry and its release.
    cu = n_up; cd = n_down;
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0);
      check("entry_in_level", in_level, k >= 6);
      check("entry_up", up, k == 7);
    end
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b0);
      check("release_in_level", in_level, k < 6);
    end
    check("entry_ups", n_up - cu, 1);
    check("entry_downs", n_down - cd, 0);

    // Glitch of DB-1 cycles rejected, DB cycles accepted.
    cd = n_down;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    check("glitch3_downs", n_down - cd, 0);
    cd = n_down;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    check("pulse4_downs", n_down - cd, 1);

    // Collision: up+collision+pending, then down.
    cu = n_up; cd = n_down;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b1);
      check("coll_up", up, k == 7);
      check("coll_flag", collision, k == 7);
      check("coll_pending", pending, k == 7);
      check("coll_down", down, k == 8);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    check("coll_ups", n_up - cu, 1);
    check("coll_downs", n_down - cd, 1);

    // Reset while an event is pending.
    for (int k = 1; k <= 7; k++) step(1'b1, 1'b1);
    check("mid_pending_before", pending, 1'b1);
    cd = n_down;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_pending", pending, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
    check("mid_rst_downs", n_down - cd, 0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b1);
      check("post_rst_up", up, k == 7);
      check("post_rst_down", down, k == 8);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);

    // Chatter stress.
    cu = n_up; cd = n_down;
    rem_b = 1000; rem_e = 50; rem_x = 30;
    total = rem_b + rem_e + rem_x;
    while (total > 0) begin
      r = $urandom_range(total - 1);
      if (r < rem_b) begin
        rem_b--;
        len = $urandom_range(DB - 1, 1);
        ch = $urandom_range(2, 0);
        for (int k = 0; k < len; k++)
          step((ch != 1) ? bit'($urandom_range(1, 0)) : 1'b0,
               (ch != 0) ? bit'($urandom_range(1, 0)) : 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0);
      end else if (r < rem_b + rem_e) begin
        rem_e--;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
      end else begin
        rem_x--;
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
      end
      total = rem_b + rem_e + rem_x;
    end
    check("chatter_ups", n_up - cu, 50);
    check("chatter_downs", n_down - cd, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
